// File: rtl/hazard_pkg.sv
// Shared types and constants for the load-use hazard scoreboard and the decoder.
package hazard_pkg;
   localparam int REG_COUNT_DEF = 8;
   localparam int MAX_LOAD_LAT  = 15;

   typedef logic [$clog2(REG_COUNT_DEF)-1:0] reg_idx_t;

   typedef struct packed {
      logic     use1;
      logic     use2;
      logic     wen;
      logic     load;
      reg_idx_t rsrc1;
      reg_idx_t rsrc2;
      reg_idx_t rdst;
   } issue_info_t;
endpackage

// File: rtl/reg_countdown.sv
// One register's outstanding-result countdown: flush beats set, set beats decrement.
module reg_countdown #(
   parameter int               CNT_W   = 1,
   parameter logic [CNT_W-1:0] SET_VAL = '1
) (
   input  logic clk,
   input  logic rst,
   input  logic flush_i,
   input  logic set_i,
   output logic busy_o
);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q;

   always_comb begin
      cnt_d = cnt_q;
      if (flush_i)            cnt_d = '0;
      else if (set_i)         cnt_d = SET_VAL;
      else if (cnt_q != '0)   cnt_d = cnt_q - CNT_W'(1);
   end

   // busy is kept as its own flop so pending_mask comes straight from a register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         busy_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         busy_q <= (cnt_d != '0);
      end
   end

   assign busy_o = busy_q;
endmodule

// File: rtl/hazard_scoreboard.sv
// Load-use / WAW hazard unit: per-register countdowns drive a combinational decode stall.
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int REG_COUNT = REG_COUNT_DEF,
   parameter int REG_W     = $clog2(REG_COUNT),
   parameter int LOAD_LAT  = 1,
   parameter int CNT_W     = $clog2(LOAD_LAT + 1),
   parameter int PERF_W    = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 dec_valid,
   input  logic [REG_W-1:0]     dec_rsrc1,
   input  logic [REG_W-1:0]     dec_rsrc2,
   input  logic                 dec_use1,
   input  logic                 dec_use2,
   input  logic [REG_W-1:0]     dec_rdst,
   input  logic                 dec_wen,
   input  logic                 dec_load,
   input  logic                 flush,
   output logic                 stallD,
   output logic [REG_COUNT-1:0] pending_mask,
   output logic [PERF_W-1:0]    stall_count
);
   localparam int               LAT     = (LOAD_LAT > MAX_LOAD_LAT) ? MAX_LOAD_LAT : LOAD_LAT;
   localparam logic [CNT_W-1:0] SET_VAL = CNT_W'(LAT);

   logic [REG_COUNT-1:0] busy, set_vec;
   logic                 raw1, raw2, waw, issue;
   logic [PERF_W-1:0]    stall_count_q, stall_count_d;

   // A load reading its own destination only sees older entries: the set lands at the edge.
   assign raw1   = dec_use1 & busy[dec_rsrc1];
   assign raw2   = dec_use2 & busy[dec_rsrc2];
   assign waw    = dec_wen  & busy[dec_rdst];
   assign stallD = dec_valid & ~flush & (raw1 | raw2 | waw);
   assign issue  = dec_valid & ~stallD & ~flush;

   always_comb begin
      set_vec = '0;
      if (issue && dec_load && dec_wen) set_vec[dec_rdst] = 1'b1;
   end

   for (genvar gi = 0; gi < REG_COUNT; gi++) begin : g_cnt
      reg_countdown #(
         .CNT_W   (CNT_W),
         .SET_VAL (SET_VAL)
      ) u_cnt (
         .clk     (clk),
         .rst     (rst),
         .flush_i (flush),
         .set_i   (set_vec[gi]),
         .busy_o  (busy[gi])
      );
   end

   always_comb begin
      stall_count_d = stall_count_q;
      if (stallD && (stall_count_q != '1)) stall_count_d = stall_count_q + PERF_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) stall_count_q <= '0;
      else     stall_count_q <= stall_count_d;
   end

   assign pending_mask = busy;
   assign stall_count  = stall_count_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: four instances (LOAD_LAT 1..4) share stimulus, one is selected per scenario.
module tb_hazard_scoreboard;
   localparam int NL = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic dec_valid, dec_use1, dec_use2, dec_wen, dec_load, flush;
   logic [2:0] dec_rsrc1, dec_rsrc2, dec_rdst;

   logic [NL-1:0]       stall_v;
   logic [NL-1:0][7:0]  pm_v;
   logic [NL-1:0][3:0]  sc_v;

   int        sel, n_chk, n_fail;
   int        want_q[$];
   logic [7:0] first_pm;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NL; g++) begin : g_dut
      hazard_scoreboard #(
         .REG_COUNT (8),
         .LOAD_LAT  (g + 1),
         .PERF_W    (4)
      ) u_dut (
         .clk          (clk),
         .rst          (rst),
         .dec_valid    (dec_valid),
         .dec_rsrc1    (dec_rsrc1),
         .dec_rsrc2    (dec_rsrc2),
         .dec_use1     (dec_use1),
         .dec_use2     (dec_use2),
         .dec_rdst     (dec_rdst),
         .dec_wen      (dec_wen),
         .dec_load     (dec_load),
         .flush        (flush),
         .stallD       (stall_v[g]),
         .pending_mask (pm_v[g]),
         .stall_count  (sc_v[g])
      );
   end

   task automatic chk(input string tag, input int obs, input int want);
      n_chk++;
      if (obs != want) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, want);
      end
   endtask

   task automatic idle();
      dec_valid = 1'b0; dec_use1 = 1'b0; dec_use2 = 1'b0; dec_wen = 1'b0; dec_load = 1'b0;
      dec_rsrc1 = '0; dec_rsrc2 = '0; dec_rdst = '0; flush = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      idle();
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   // Hold one instruction in decode until the selected DUT lets it issue; compare bubble count.
   task automatic send(input string tag, input logic u1, input logic [2:0] r1, input logic u2,
                       input logic [2:0] r2, input logic w, input logic [2:0] rd,
                       input logic ld, input int want_stalls);
      int stalls;
      int want;
      want_q.push_back(want_stalls);
      dec_valid = 1'b1; dec_use1 = u1; dec_rsrc1 = r1; dec_use2 = u2; dec_rsrc2 = r2;
      dec_wen = w; dec_rdst = rd; dec_load = ld; flush = 1'b0;
      stalls = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (i == 0) first_pm = pm_v[sel];
         if (!stall_v[sel]) break;
         stalls++;
         @(posedge clk);
         #1;
      end
      want = want_q.pop_front();
      chk(tag, stalls, want);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_chk = 0; n_fail = 0; sel = 0;
      idle();
      rst = 1'b1;
      #1;
      for (int g = 0; g < NL; g++) begin
         chk("rst_stall", int'(stall_v[g]), 0);
         chk("rst_pmask", int'(pm_v[g]), 0);
         chk("rst_scount", int'(sc_v[g]), 0);
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // LOAD_LAT=1: self-sourced load, then a single-bubble consumer
      sel = 0;
      send("lat1_ld_self", 1'b1, 3'd3, 1'b0, 3'd0, 1'b1, 3'd3, 1'b1, 0);
      send("lat1_add",     1'b1, 3'd3, 1'b1, 3'd5, 1'b1, 3'd1, 1'b0, 1);
      idle();
      @(negedge clk);
      chk("lat1_scount", int'(sc_v[sel]), 1);

      // LOAD_LAT=3: rsrc2 consumer, unused source, WAW, idle-cycle decrement
      sel = 2;
      do_reset();
      send("lat3_ld",       1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 3'd2, 1'b1, 0);
      send("lat3_use2",     1'b0, 3'd2, 1'b1, 3'd2, 1'b1, 3'd5, 1'b0, 3);
      chk("lat3_pmask", int'(first_pm), 4);
      send("lat3_ld_b",     1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 3'd2, 1'b1, 0);
      send("lat3_nouse",    1'b0, 3'd2, 1'b0, 3'd2, 1'b1, 3'd5, 1'b0, 0);
      send("lat3_ld_waw",   1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 3'd2, 1'b1, 2);
      idle_cycles(1);
      send("lat3_use_late", 1'b0, 3'd0, 1'b1, 3'd2, 1'b0, 3'd0, 1'b0, 2);
      idle();
      @(negedge clk);
      chk("lat3_scount", int'(sc_v[sel]), 7);

      // LOAD_LAT=2: WAW on a non-load, then two independent countdowns
      sel = 1;
      do_reset();
      send("lat2_ld_r6",  1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 3'd6, 1'b1, 0);
      send("lat2_waw",    1'b0, 3'd6, 1'b0, 3'd6, 1'b1, 3'd6, 1'b0, 2);
      idle_cycles(3);
      send("lat2_ld_r1",  1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 3'd1, 1'b1, 0);
      send("lat2_ld_r4",  1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 3'd4, 1'b1, 0);
      send("lat2_use_r4", 1'b1, 3'd4, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 2);
      chk("lat2_pmask", int'(first_pm), 8'h12);
      idle_cycles(3);
      send("lat2_ld_r1b", 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 3'd1, 1'b1, 0);
      send("lat2_ld_r4b", 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 3'd4, 1'b1, 0);
      send("lat2_use_r1", 1'b0, 3'd0, 1'b1, 3'd1, 1'b0, 3'd0, 1'b0, 1);

      // LOAD_LAT=4: flush while a consumer is stalled
      sel = 3;
      do_reset();
      send("lat4_ld_r7", 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 3'd7, 1'b1, 0);
      dec_valid = 1'b1; dec_use1 = 1'b1; dec_rsrc1 = 3'd7; dec_wen = 1'b0; dec_load = 1'b0;
      @(negedge clk);
      chk("flush_pre_stall", int'(stall_v[sel]), 1);
      @(posedge clk); #1;
      flush = 1'b1;
      @(negedge clk);
      chk("flush_stall", int'(stall_v[sel]), 0);
      @(posedge clk); #1;
      flush = 1'b0;
      @(negedge clk);
      chk("flush_pmask", int'(pm_v[sel]), 0);
      chk("flush_scount", int'(sc_v[sel]), 1);
      chk("flush_after_stall", int'(stall_v[sel]), 0);
      @(posedge clk); #1;

      // Saturation: back-to-back WAW loads give 20 stall cycles, counter tops out at 15
      do_reset();
      send("sat_ld0", 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 3'd7, 1'b1, 0);
      for (int k = 0; k < 5; k++)
         send("sat_ld", 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 3'd7, 1'b1, 4);
      idle();
      @(negedge clk);
      chk("sat_scount", int'(sc_v[sel]), 15);
      dec_valid = 1'b1; dec_use1 = 1'b1; dec_rsrc1 = 3'd7;
      #1;
      chk("sat_midstall", int'(stall_v[sel]), 1);
      #1;
      rst = 1'b1;
      #1;
      chk("arst_stall", int'(stall_v[sel]), 0);
      chk("arst_pmask", int'(pm_v[sel]), 0);
      chk("arst_scount", int'(sc_v[sel]), 0);
      idle();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised load-use hazard unit that replaces the single-cycle, EX-stage-only load check.
- Keeps a per-register countdown of outstanding multi-cycle results, so the decode stage stalls for the exact number of bubbles any load latency requires.
- Source usage comes from decoder flags instead of an internal opcode table.
- Also stalls write-after-write conflicts, supports pipeline flush, and exposes a saturating stall counter for performance monitoring.

Parameters:
- REG_COUNT, 8, number of architectural registers.
- REG_W, $clog2(REG_COUNT), register index width (derived).
- LOAD_LAT, 1, bubbles needed between a load leaving decode and a consumer leaving decode (1..15).
- CNT_W, $clog2(LOAD_LAT+1), per-register countdown width (derived).
- PERF_W, 16, stall counter width.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous, active-high reset.
- dec_valid  in  1  decode stage holds a valid instruction.
- dec_rsrc1  in  REG_W  first source index.
- dec_rsrc2  in  REG_W  second source index.
- dec_use1  in  1  instruction reads rsrc1.
- dec_use2  in  1  instruction reads rsrc2.
- dec_rdst  in  REG_W  destination index.
- dec_wen  in  1  instruction writes rdst.
- dec_load  in  1  instruction is a load (result late by LOAD_LAT).
- flush  in  1  squash all in-flight tracking (branch/interrupt).
- stallD  out  1  hold decode and insert a bubble into EX; combinational.
- pending_mask  out  REG_COUNT  bit r = register r has a nonzero countdown; registered.
- stall_count  out  PERF_W  saturating count of stalled cycles.

Behaviour:
- Reset (asynchronous): all countdowns = 0, pending_mask = 0, stall_count = 0. stallD is then 0 because the counters are zero.
- State is cnt[r] (CNT_W bits) for each register r.
- Hazard terms, all combinational:
  - raw1 = dec_use1 and cnt[rsrc1] != 0
  - raw2 = dec_use2 and cnt[rsrc2] != 0
  - waw = dec_wen and cnt[rdst] != 0
- stallD = dec_valid and not flush and (raw1 or raw2 or waw).
- An instruction issues when dec_valid and not stallD and not flush.
- Per-cycle update, priority order:
  1. If flush: all cnt = 0, and nothing is set this cycle.
  2. Else if issue and dec_load and dec_wen: cnt[rdst] = LOAD_LAT. Setting overrides a decrement of the same entry.
  3. Every other entry with a nonzero count decrements by 1.
- Non-load writes never set a counter; their results reach consumers through normal forwarding.
- Timing with LOAD_LAT = N:
  - Load issues at cycle t.
  - A dependent instruction in decode at t+1 stalls for cycles t+1..t+N.
  - It issues at t+N+1.
  - N = 1 gives a single bubble, the legacy behaviour.
- Source and destination aliasing: rsrc1 = rsrc2 = rdst is legal. Each term is evaluated independently; no double counting.
- A load whose destination is also its own source checks only against older pending entries. It never hazards against itself.
- pending_mask[r] is the registered value of (cnt[r] != 0).
- stall_count increments by 1 on every cycle where stallD = 1 and saturates at all-ones.
  - Flush does not clear it; only reset does.
- rst asserted mid-stall: stallD drops immediately (asynchronously) and all tracking is lost.
- Decode with dec_valid = 0: no stall and no issue, but counters still decrement.

Decomposition:
- Shared package hazard_pkg:
  - REG_COUNT default.
  - Register index typedef.
  - Maximum LOAD_LAT constant.
  - An issue-info struct {use1, use2, wen, load, rsrc1, rsrc2, rdst} for reuse by the decoder.
- One natural sub-module, reg_countdown: a single CNT_W counter with set, flush and decrement priority. It is instantiated REG_COUNT times via generate.
- Hazard compare and the perf counter stay in the top module.

Test Plan:
- LOAD_LAT=1: load to r3 issues at t; ADD using r3,r5 in decode at t+1 -> stallD=1 for exactly 1 cycle, issues at t+2, stall_count=1.
- LOAD_LAT=3: load to r2, then consumer using rsrc2=r2 -> stallD high cycles t+1..t+3, pending_mask=0b00000100 during stall; consumer with use2=0 and same indices -> no stall.
- WAW: load to r6 (LOAD_LAT=2), next instruction is a non-load writing r6 with no sources used -> 2 stall cycles, then issues.
- Back-to-back loads to r1 and r4 (LOAD_LAT=2) -> independent countdowns; consumer of r4 in decode right after the second load stalls 2 cycles, consumer of r1 stalls 1 cycle.
- Flush: load to r7 (LOAD_LAT=4), flush at t+2 while a consumer is stalled -> stallD=0 at t+2, pending_mask=0 at t+3, stall_count=1.
- Reset and saturation: hold a stall with PERF_W=4 for 20 cycles -> stall_count=15; assert rst mid-stall -> stallD=0, pending_mask=0, stall_count=0 before the next clk edge.
